// File: rtl/key_debouncer.sv
// Pushbutton conditioner: two-flop synchronizer, restart-on-bounce debounce, press/release/long pulses, press counter.
// Define KEY_AUTOREPEAT_EN to add periodic KEY_PRESS repeats while the key is in the long-held state.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int CNT_W           = 8
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             KEY_N,
  output logic             KEY_LEVEL,
  output logic             KEY_PRESS,
  output logic             KEY_RELEASE,
  output logic             KEY_LONG,
  output logic [CNT_W-1:0] PRESS_COUNT
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_param_check
    $error("key_debouncer: invalid parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  state_t             state_q, state_d;
  logic               syncMeta_q, syncOut_q;
  logic [DB_W-1:0]    dbCnt_q, dbCnt_d;
  logic [HOLD_W-1:0]  holdCnt_q, holdCnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               long_q, long_d;
  logic               keyS;
  logic               keyLevel;
  logic               accept;

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES);
  logic [REP_W-1:0] repCnt_q, repCnt_d;
`endif

  assign keyS     = ~syncOut_q;
  assign keyLevel = (state_q != IDLE);

  // Any sample that agrees with the accepted level throws away all accumulated credit.
  always_comb begin
    accept  = 1'b0;
    dbCnt_d = '0;
    if (keyS != keyLevel) begin
      if (dbCnt_q == DB_LAST) begin
        accept = 1'b1;
      end else begin
        dbCnt_d = dbCnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    count_d   = count_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    repCnt_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = PRESSED;
          press_d   = 1'b1;
          count_d   = count_q + 1'b1;
          holdCnt_d = '0;
        end
      end
      PRESSED: begin
        // A release on the threshold cycle suppresses the long pulse.
        if (accept) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          holdCnt_d = holdCnt_q + 1'b1;
          if (holdCnt_d == HOLD_LAST) begin
            state_d = LONG_HELD;
            long_d  = 1'b1;
          end
        end
      end
      LONG_HELD: begin
        if (accept) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
`ifdef KEY_AUTOREPEAT_EN
        else begin
          repCnt_d = repCnt_q + 1'b1;
          if (repCnt_d == REP_LAST) begin
            repCnt_d = '0;
            press_d  = 1'b1;
            count_d  = count_q + 1'b1;
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      syncMeta_q <= 1'b1;
      syncOut_q  <= 1'b1;
      state_q    <= IDLE;
      dbCnt_q    <= '0;
      holdCnt_q  <= '0;
      count_q    <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      repCnt_q   <= '0;
`endif
    end else begin
      syncMeta_q <= KEY_N;
      syncOut_q  <= syncMeta_q;
      state_q    <= state_d;
      dbCnt_q    <= dbCnt_d;
      holdCnt_q  <= holdCnt_d;
      count_q    <= count_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
`ifdef KEY_AUTOREPEAT_EN
      repCnt_q   <= repCnt_d;
`endif
    end
  end

  assign KEY_LEVEL   = keyLevel;
  assign KEY_PRESS   = press_q;
  assign KEY_RELEASE = release_q;
  assign KEY_LONG    = long_q;
  assign PRESS_COUNT = count_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: directed table, corner sequences and random stimulus vs a behavioural model.
module tb_key_debouncer;

  localparam int DB  = 4;
  localparam int LNG = 20;
  localparam int REP = 5;
  localparam int CW  = 3;

  logic clk = 1'b0;
  logic RESET_N = 1'b0;
  logic KEY_N = 1'b1;
  logic KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_LONG;
  logic [CW-1:0] PRESS_COUNT;

  int compared = 0;
  int mismatched = 0;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LNG),
    .REPEAT_CYCLES(REP),
    .CNT_W(CW)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N(RESET_N),
    .KEY_N(KEY_N),
    .KEY_LEVEL(KEY_LEVEL),
    .KEY_PRESS(KEY_PRESS),
    .KEY_RELEASE(KEY_RELEASE),
    .KEY_LONG(KEY_LONG),
    .PRESS_COUNT(PRESS_COUNT)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw samples delayed two edges, level flips after DB consecutive disagreeing samples.
  bit rawOld, rawNew;
  bit mLevel;
  int mRun, mAge, mCount;
  bit mLongDone;
  bit ePress, eRel, eLong;

  int cycle = 0;
  int nPress, nRel, nLong;
  int firstPressCyc, longCyc, relCyc;
  int pressCounts[$];

  task automatic modelEdge(input bit keyN, input bit rstN);
    bit obs;
    ePress = 0; eRel = 0; eLong = 0;
    if (!rstN) begin
      rawOld = 1; rawNew = 1; mLevel = 0; mRun = 0; mAge = 0; mLongDone = 0; mCount = 0;
      return;
    end
    obs = !rawOld;
    rawOld = rawNew;
    rawNew = keyN;
    mRun = (obs != mLevel) ? mRun + 1 : 0;
    if (mRun == DB) begin
      mRun = 0;
      mLevel = obs;
      if (obs) begin
        ePress = 1; mCount = (mCount + 1) % (1 << CW); mAge = 0; mLongDone = 0;
      end else begin
        eRel = 1;
      end
    end else if (mLevel) begin
      mAge++;
      if (!mLongDone && mAge == LNG - 1) begin
        eLong = 1; mLongDone = 1;
      end
`ifdef KEY_AUTOREPEAT_EN
      else if (mLongDone && ((mAge - (LNG - 1)) % REP) == 0) begin
        ePress = 1; mCount = (mCount + 1) % (1 << CW);
      end
`endif
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cycle, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("model KEY_LEVEL", KEY_LEVEL, mLevel);
    checkVal("model KEY_PRESS", KEY_PRESS, ePress);
    checkVal("model KEY_RELEASE", KEY_RELEASE, eRel);
    checkVal("model KEY_LONG", KEY_LONG, eLong);
    checkVal("model PRESS_COUNT", PRESS_COUNT, mCount);
  endtask

  task automatic clearTrack();
    nPress = 0; nRel = 0; nLong = 0;
    firstPressCyc = -1; longCyc = -1; relCyc = -1;
    pressCounts.delete();
  endtask

  // Drives one cycle of inputs from the falling edge, then checks after the next rising edge.
  task automatic applyStimulus(input bit keyN, input bit rstN);
    KEY_N = keyN;
    RESET_N = rstN;
    @(posedge clk);
    modelEdge(keyN, rstN);
    cycle++;
    @(negedge clk);
    if (KEY_PRESS === 1'b1) begin
      nPress++;
      pressCounts.push_back(int'(PRESS_COUNT));
      if (firstPressCyc < 0) firstPressCyc = cycle;
    end
    if (KEY_RELEASE === 1'b1) begin nRel++; relCyc = cycle; end
    if (KEY_LONG === 1'b1) begin nLong++; longCyc = cycle; end
    checkOutput();
  endtask

  typedef struct {
    bit keyN;
    bit rstN;
    bit lvl;
    bit prs;
    bit rel;
    bit lng;
    int cnt;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int rstCyc, riseCyc, pressBefore;
    bit key;

    // Clean press at row 3 accepted at row 8; release at row 11 accepted at row 16.
    for (int i = 0; i < 18; i++) begin
      vecs[i].keyN = !(i >= 3 && i <= 10);
      vecs[i].rstN = (i != 0);
      vecs[i].lvl  = (i >= 8 && i <= 15);
      vecs[i].prs  = (i == 8);
      vecs[i].rel  = (i == 16);
      vecs[i].lng  = 1'b0;
      vecs[i].cnt  = (i >= 8) ? 1 : 0;
    end

    @(negedge clk);
    clearTrack();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].keyN, vecs[i].rstN);
      checkVal("table KEY_LEVEL", KEY_LEVEL, vecs[i].lvl);
      checkVal("table KEY_PRESS", KEY_PRESS, vecs[i].prs);
      checkVal("table KEY_RELEASE", KEY_RELEASE, vecs[i].rel);
      checkVal("table KEY_LONG", KEY_LONG, vecs[i].lng);
      checkVal("table PRESS_COUNT", PRESS_COUNT, vecs[i].cnt);
    end

    // Bounce: runs shorter than the debounce window must never be accepted.
    clearTrack();
    pressBefore = int'(PRESS_COUNT);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1);
    checkVal("bounce press pulses", nPress, 0);
    checkVal("bounce level", KEY_LEVEL, 0);
    checkVal("bounce count", PRESS_COUNT, pressBefore);

    // Long press held 40 cycles.
    clearTrack();
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1);
    riseCyc = cycle + 1;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1);
    checkVal("long pulse count", nLong, 1);
    checkVal("long delay after press", longCyc - firstPressCyc, LNG - 1);
    checkVal("long release count", nRel, 1);
    checkVal("release delay after rise", relCyc - riseCyc, DB + 1);
`ifdef KEY_AUTOREPEAT_EN
    checkVal("autorepeat press pulses", nPress, 5);
    checkVal("autorepeat last count", pressCounts[pressCounts.size()-1], (1 + 5) % 8);
`else
    checkVal("long press pulses", nPress, 1);
`endif

    // Wrap: nine clean presses from a fresh reset.
    applyStimulus(1'b1, 1'b0);
    clearTrack();
    for (int p = 0; p < 9; p++) begin
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1);
    end
    checkVal("wrap release pulses", nRel, 9);
    checkVal("wrap press pulses", nPress, 9);
    for (int p = 0; p < pressCounts.size(); p++) checkVal("wrap count sequence", pressCounts[p], (p + 1) % 8);
    checkVal("wrap final count", PRESS_COUNT, 1);

    // Reset while held in PRESSED; the still-held key must be re-debounced.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1);
    checkVal("pre-reset level", KEY_LEVEL, 1);
    applyStimulus(1'b0, 1'b0);
    rstCyc = cycle;
    checkVal("reset level", KEY_LEVEL, 0);
    checkVal("reset press", KEY_PRESS, 0);
    checkVal("reset count", PRESS_COUNT, 0);
    clearTrack();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1);
    checkVal("post-reset press delay", firstPressCyc - rstCyc, DB + 2);
    checkVal("post-reset count", PRESS_COUNT, 1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1);

    // Random runs of varying length with occasional resets.
    key = 1'b1;
    for (int r = 0; r < 250; r++) begin
      int len;
      key = ($urandom_range(0, 3) == 0) ? key : !key;
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(18, 32) : $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        applyStimulus(key, ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
        checkVal("press/release exclusive", KEY_PRESS & KEY_RELEASE, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Input-side counterpart of the LED blink/driver blocks: conditions a raw DE2 pushbutton (KEY_N, active-low, bouncing, asynchronous) into clean CLOCK_50-domain events.
- Produces a debounced level, single-cycle press/release pulses, a long-press pulse (1 s default) and a wrapping press counter.
- Sits between board KEY pins and control logic (mode select, LED sequencers).

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); minimum 2.
- LONG_CYCLES, 50000000, cycles held after the accepted press before KEY_LONG fires (1 s at 50 MHz); must exceed DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 10000000, auto-repeat period (200 ms); used only with the optional feature.
- CNT_W, 8, width of PRESS_COUNT.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz, all logic on rising edge.
- RESET_N  input  1  synchronous active-low reset, sampled on CLOCK_50 rising edge.
- KEY_N  input  1  raw pushbutton, 0 = pressed, asynchronous.
- KEY_LEVEL  output  1  debounced level, 1 = pressed.
- KEY_PRESS  output  1  one-cycle pulse on accepted press (and on each auto-repeat).
- KEY_RELEASE  output  1  one-cycle pulse on accepted release.
- KEY_LONG  output  1  one-cycle pulse, once per press, at long-press threshold.
- PRESS_COUNT  output  CNT_W  number of accepted presses, modulo 2^CNT_W.

Behaviour:
- Reset (RESET_N=0 at clock edge): state IDLE, all counters 0, synchronizer flops loaded with 1 (released), KEY_LEVEL/KEY_PRESS/KEY_RELEASE/KEY_LONG=0, PRESS_COUNT=0. Reset wins over every other event in the same cycle.
- Synchronizer: two flops on KEY_N; key_s = inverted second-flop output. No other logic sees KEY_N.
- Debounce counter db_cnt: cleared whenever key_s equals KEY_LEVEL; otherwise increments. When db_cnt reaches DEBOUNCE_CYCLES-1 while key_s still differs, the change is accepted on that edge and db_cnt clears. Any single-cycle bounce back clears db_cnt (restart, no partial credit).
- Latency: KEY_N held low from edge k -> KEY_LEVEL=1 and KEY_PRESS=1 at edge k+2+DEBOUNCE_CYCLES. Same latency for release.
- States:
  - IDLE: KEY_LEVEL=0. Accepted press -> PRESSED; KEY_PRESS pulse; PRESS_COUNT+1 (wraps 2^CNT_W-1 -> 0); hold_cnt cleared.
  - PRESSED: hold_cnt increments each cycle. hold_cnt reaching LONG_CYCLES-1 -> LONG_HELD with KEY_LONG pulse. Accepted release -> IDLE with KEY_RELEASE pulse.
  - LONG_HELD: hold_cnt frozen; no further KEY_LONG. Accepted release -> IDLE with KEY_RELEASE pulse.
- Simultaneous long threshold and accepted release in PRESSED: release wins, KEY_LONG not issued.
- hold_cnt width = $clog2(LONG_CYCLES+1); never wraps (frozen in LONG_HELD).
- Pulse outputs are registered, high exactly one cycle; KEY_PRESS and KEY_RELEASE never high together.
- Reset mid-press: outputs cleared; button still held after reset release is re-debounced and yields a fresh KEY_PRESS after 2+DEBOUNCE_CYCLES cycles, PRESS_COUNT=1.

Optional Feature:
- Macro KEY_AUTOREPEAT_EN.
- Defined: in LONG_HELD a repeat counter runs; KEY_PRESS pulses every REPEAT_CYCLES cycles (first repeat REPEAT_CYCLES after KEY_LONG); each repeat increments PRESS_COUNT. Release stops repeats immediately; repeat counter cleared on leaving LONG_HELD.
- Not defined: no repeat counter in the netlist; KEY_PRESS only on accepted press.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, CNT_W=3):
- Clean press: KEY_N 1->0 at edge 10, held -> KEY_PRESS single pulse at edge 16, KEY_LEVEL=1 from 16, PRESS_COUNT=1.
- Bounce: KEY_N low 3 cycles, high 1, low 3, high -> no KEY_PRESS, KEY_LEVEL stays 0, PRESS_COUNT=0.
- Long press: hold 40 cycles -> KEY_PRESS at t, KEY_LONG single pulse at t+19, no second KEY_LONG; release -> KEY_RELEASE 6 cycles after KEY_N rises.
- Wrap: 9 clean press/release pairs -> PRESS_COUNT sequence 1..7,0,1; 9 KEY_RELEASE pulses.
- Reset mid-hold: RESET_N=0 for 1 cycle while held in PRESSED -> all outputs 0 next cycle; KEY_PRESS again 6 cycles after RESET_N=1, PRESS_COUNT=1.
- KEY_AUTOREPEAT_EN: hold 40 cycles -> KEY_PRESS at t, t+24, t+29, t+34, t+39; PRESS_COUNT=5; none after release accepted.
